divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 24 ++
 rtl/divider.sv | 96 +++++++++
 tb/tb_divider.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: opcodes, FSM states, default width.
package div_pkg;
    localparam int DEFAULT_WIDTH = 32;

    localparam logic [5:0] DIVU = 6'b011011;
    localparam logic [5:0] OUT  = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on the {remainder, quotient} working value:
// shift left, then subtract the divisor from the upper part when it fits.
module div_step #(
    parameter int WIDTH = div_pkg::DEFAULT_WIDTH
) (
    input  logic [2*WIDTH:0]  work_i,
    input  logic [WIDTH-1:0]  divisor_i,
    output logic [2*WIDTH:0]  work_o
);
    logic [WIDTH+1:0] upper;
    logic [WIDTH+1:0] diff;
    logic             fits;

    always_comb begin
        // Upper part after the shift, widened by one bit so the borrow is visible.
        upper  = work_i[2*WIDTH:WIDTH-1];
        diff   = upper - {2'b00, divisor_i};
        fits   = ~diff[WIDTH+1];
        work_o = {work_i[2*WIDTH-1:0], 1'b0};
        if (fits) begin
            work_o = {diff[WIDTH:0], work_i[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: 32 iterations per DIVU, result held
// internally and published to dataOut only on an OUT command.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    input  logic [5:0]           Signal,
    output logic [2*WIDTH-1:0]   dataOut,
    output logic                 busy,
    output logic                 done,
    output logic                 divByZero
);
    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e         state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH:0]   work_q;
    logic [2*WIDTH:0]   work_d;
    logic [WIDTH-1:0]   divisor_q;
    logic [2*WIDTH-1:0] result_q;
    logic [2*WIDTH-1:0] data_out_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (work_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            // done trails the DONE state by one cycle, so it never overlaps busy.
            done_q <= (state_q == DONE);
            if (Signal == OUT) begin
                data_out_q <= result_q;
            end
            case (state_q)
                IDLE: begin
                    if (Signal == DIVU) begin
                        divisor_q <= dataB;
                        cnt_q     <= '0;
                        work_q    <= {1'b0, {WIDTH{1'b0}}, dataA};
                        busy_q    <= 1'b1;
                        if (dataB == '0) begin
                            dbz_q    <= 1'b1;
                            result_q <= {dataA, {WIDTH{1'b1}}};
                            state_q  <= DONE;
                        end else begin
                            dbz_q   <= 1'b0;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        result_q <= work_d[2*WIDTH-1:0];
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dataOut   = data_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign divByZero = dbz_q;
endmodule

// File: tb/tb_divider.sv
// Bench for divider: directed cases, abort/ignore scenarios and random operands,
// results tracked through an expected-value queue.
module tb_divider;
    import div_pkg::*;

    localparam logic [5:0]  NOP    = 6'b000000;
    localparam logic [31:0] MAX32  = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [63:0] dataOut;
    logic        busy;
    logic        done;
    logic        divByZero;

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .dataA     (dataA),
        .dataB     (dataB),
        .Signal    (Signal),
        .dataOut   (dataOut),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        Signal = NOP;
        dataA  = '0;
        dataB  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Waits up to max_edges rising edges for done; lat = edge index, or -1.
    task automatic wait_done(input int max_edges, output int lat);
        lat = -1;
        for (int i = 1; i <= max_edges && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (done) lat = i;
        end
    endtask

    task automatic publish();
        Signal = OUT;
        @(posedge clk);
        #1;
        Signal = NOP;
    endtask

    task automatic compare_result(input string tag);
        logic [63:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            exp = exp_q.pop_front();
            check(tag, dataOut, exp);
        end
    endtask

    // Full transaction: start, wait for done, publish in the done cycle, compare.
    task automatic div_txn(input logic [31:0] a, input logic [31:0] b, input bit prop);
        int          lat;
        logic [31:0] q_o;
        logic [31:0] r_o;
        exp_q.push_back((b == 0) ? {a, MAX32} : {a % b, a / b});
        Signal = DIVU;
        dataA  = a;
        dataB  = b;
        @(posedge clk);
        #1;
        Signal = NOP;
        dataA  = $urandom;
        dataB  = $urandom;
        check("busy_after_start", 64'(busy), 64'd1);
        wait_done(60, lat);
        check("latency", 64'(lat), (b == 0) ? 64'd1 : 64'd33);
        check("div_by_zero", 64'(divByZero), (b == 0) ? 64'd1 : 64'd0);
        publish();
        compare_result("result");
        if (prop && b != 0) begin
            q_o = dataOut[31:0];
            r_o = dataOut[63:32];
            check("prop_sum", 64'(q_o) * 64'(b) + 64'(r_o), 64'(a));
            check("prop_rem_lt_div", 64'(r_o < b), 64'd1);
        end
    endtask

    function automatic logic [31:0] pick_a();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return MAX32;
            3:       return $urandom;
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    function automatic logic [31:0] pick_b(input logic [31:0] a);
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return MAX32;
            3:       return $urandom;
            4:       return (a > MAX32 - 32'd1000) ? MAX32 : a + 32'($urandom_range(1, 1000));
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    initial begin
        int lat;
        int done_seen;

        do_reset();
        check("reset_dataOut", dataOut, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dbz", 64'(divByZero), 64'd0);

        div_txn(32'd100, 32'd7, 1'b1);
        div_txn(MAX32, 32'd1, 1'b1);
        div_txn(32'd3, 32'd10, 1'b1);
        div_txn(32'd5, 32'd0, 1'b0);
        div_txn(32'd9, 32'd3, 1'b1);

        // DIVU while running is ignored; OUT mid-run shows the previous result.
        exp_q.push_back(64'h00000002_0000000E);
        Signal = DIVU; dataA = 32'd100; dataB = 32'd7;
        @(posedge clk); #1;
        Signal = NOP;
        repeat (10) @(posedge clk);
        #1;
        Signal = DIVU; dataA = 32'd50; dataB = 32'd5;
        @(posedge clk); #1;
        Signal = NOP;
        check("busy_ignore", 64'(busy), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        publish();
        check("out_during_run", dataOut, 64'h00000000_00000003);
        wait_done(40, lat);
        check("latency_ignore", 64'(lat), 64'd13);
        check("dbz_ignore", 64'(divByZero), 64'd0);
        publish();
        compare_result("result_ignore");

        // Reset mid-run abandons the division.
        Signal = DIVU; dataA = 32'd77; dataB = 32'd3;
        @(posedge clk); #1;
        Signal = NOP;
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        Signal = DIVU; dataA = 32'd81; dataB = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        Signal = NOP;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_dataOut", dataOut, 64'd0);
        check("abort_dbz", 64'(divByZero), 64'd0);
        publish();
        check("abort_result_cleared", dataOut, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        div_txn(32'd81, 32'd9, 1'b1);

        // Start on the first edge after reset release.
        do_reset();
        div_txn(32'd1000, 32'd33, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = pick_a();
            b = pick_b(a);
            div_txn(a, b, 1'b1);
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
